// File: rtl/merger_tree_leaf_feeder.sv
// merger_tree_leaf_feeder
//   Producer side of the merger tree's leaf interface. Keeps NUM_LEAVES
//   show-ahead FIFOs, exposes each head item and an empty flag to the tree,
//   pops a head on the tree's read strobe, and keeps the leaves topped up by
//   issuing credit-checked, round-robin burst refill requests to memory.
//   Tagged response beats are written into the addressed leaf.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            one-cycle pulse: clear all leaf state, enable requests
//   o_fifo             head item of leaf k at [DATA_WIDTH*k +: DATA_WIDTH]
//   o_fifo_empty       bit k set when leaf k is empty
//   i_fifo_read        bit k pops the head of leaf k (ignored when empty)
//   o_req_valid/leaf   refill request, held until i_req_ready
//   i_req_ready        memory engine accepts the request
//   i_rsp_*            response beat (valid, leaf tag, data, last-of-run)
//   o_leaf_done        bit k set once leaf k has received its last item
//   o_overflow         sticky: a beat hit a full leaf and was dropped
//
// NUM_LEAVES must equal 2**LEAF_W and DEPTH must be a power of two >= BURST.
module merger_tree_leaf_feeder #(
  parameter int NUM_LEAVES = 128,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int BURST      = 4,
  parameter int LEAF_W     = 7
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  output logic [DATA_WIDTH*NUM_LEAVES-1:0] o_fifo,
  output logic [NUM_LEAVES-1:0]            o_fifo_empty,
  input  logic [NUM_LEAVES-1:0]            i_fifo_read,
  output logic                             o_req_valid,
  output logic [LEAF_W-1:0]                o_req_leaf,
  input  logic                             i_req_ready,
  input  logic                             i_rsp_valid,
  input  logic [LEAF_W-1:0]                i_rsp_leaf,
  input  logic [DATA_WIDTH-1:0]            i_rsp_data,
  input  logic                             i_rsp_last,
  output logic [NUM_LEAVES-1:0]            o_leaf_done,
  output logic                             o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;   // holds 0..DEPTH
  localparam int SUM_W = CNT_W + 1;   // room for count + pending + BURST

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0]  SUM_ONE   = SUM_W'(1);
  localparam logic [SUM_W-1:0]  SUM_BURST = SUM_W'(BURST);
  localparam logic [SUM_W-1:0]  SUM_DEPTH = SUM_W'(DEPTH);
  localparam logic [LEAF_W-1:0] LEAF_ONE  = LEAF_W'(1);
  localparam logic [LEAF_W-1:0] LEAF_LAST = LEAF_W'(NUM_LEAVES - 1);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  // Outstanding-credit update: a handshake adds BURST, an accepted beat
  // takes one (never below zero), and the last beat of a run clears it.
  function automatic logic [CNT_W-1:0] next_pending(input logic [CNT_W-1:0] cur,
                                                    input logic add, input logic sub,
                                                    input logic last);
    logic [SUM_W-1:0] s;
    s = {1'b0, cur} + (add ? SUM_BURST : '0);
    if (sub && (s != '0)) s = s - SUM_ONE;
    if (sub && last)      s = '0;
    if (s > SUM_DEPTH)    s = SUM_DEPTH;
    return s[CNT_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_LEAVES][DEPTH];
  logic [PTR_W-1:0]      rd_ptr [NUM_LEAVES];
  logic [PTR_W-1:0]      wr_ptr [NUM_LEAVES];
  logic [CNT_W-1:0]      count [NUM_LEAVES];
  logic [CNT_W-1:0]      pending [NUM_LEAVES];
  logic [CNT_W-1:0]      pending_nxt [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] done, pop, wr, elig;
  logic                  en, overflow, ovf_hit, hs, found;
  logic [LEAF_W-1:0]     rr_ptr, pick, req_leaf_q, req_leaf_d;
  state_t                state_q, state_d;

  assign hs = (state_q == ST_REQ) && i_req_ready && !i_start;

  // Per-leaf pop/write decisions, overflow detection and eligibility.
  // A pop frees the slot in the same cycle, so a full leaf being popped
  // still accepts a beat.
  always_comb begin
    ovf_hit = 1'b0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      pop[k]  = i_fifo_read[k] && (count[k] != '0);
      wr[k]   = i_rsp_valid && (i_rsp_leaf == LEAF_W'(k)) && ((count[k] != CNT_FULL) || pop[k]);
      ovf_hit = ovf_hit | (i_rsp_valid && (i_rsp_leaf == LEAF_W'(k)) &&
                           (count[k] == CNT_FULL) && !pop[k]);
      elig[k] = en && !done[k] &&
                (({1'b0, count[k]} + {1'b0, pending[k]} + SUM_BURST) <= SUM_DEPTH);
      pending_nxt[k] = next_pending(pending[k], hs && (req_leaf_q == LEAF_W'(k)),
                                    wr[k], i_rsp_last);
    end
  end

  // Round-robin search: first eligible leaf at or after rr_ptr, wrapping.
  always_comb begin
    logic [LEAF_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      idx = rr_ptr + LEAF_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Leaf storage holds data only; pointers and counts decide visibility.
  always_ff @(posedge i_clk) begin
    if (!i_start && wr[i_rsp_leaf]) mem[i_rsp_leaf][wr_ptr[i_rsp_leaf]] <= i_rsp_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        rd_ptr[k]  <= '0;
        wr_ptr[k]  <= '0;
        count[k]   <= '0;
        pending[k] <= '0;
      end
      done     <= '0;
      en       <= 1'b0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
    end else if (i_start) begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        rd_ptr[k]  <= '0;
        wr_ptr[k]  <= '0;
        count[k]   <= '0;
        pending[k] <= '0;
      end
      done     <= '0;
      en       <= 1'b1;
      overflow <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      for (int k = 0; k < NUM_LEAVES; k++) begin
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
        if (wr[k])  wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
        if (wr[k] && !pop[k])      count[k] <= count[k] + CNT_ONE;
        else if (pop[k] && !wr[k]) count[k] <= count[k] - CNT_ONE;
        pending[k] <= pending_nxt[k];
        if (wr[k] && i_rsp_last) done[k] <= 1'b1;
      end
      if (ovf_hit) overflow <= 1'b1;
      if (hs) rr_ptr <= (req_leaf_q == LEAF_LAST) ? '0 : req_leaf_q + LEAF_ONE;
    end
  end

  // Request FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      req_leaf_q <= '0;
    end else begin
      state_q    <= state_d;
      req_leaf_q <= req_leaf_d;
    end
  end

  // Request FSM: next state. The chosen leaf is registered so the request
  // appears one cycle after the leaf becomes eligible.
  always_comb begin
    state_d    = state_q;
    req_leaf_d = req_leaf_q;
    if (i_start) begin
      state_d    = ST_IDLE;
      req_leaf_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (found) begin
          state_d    = ST_REQ;
          req_leaf_d = pick;
        end
        ST_REQ:  if (i_req_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Request FSM: outputs
  always_comb begin
    o_req_valid = (state_q == ST_REQ);
    o_req_leaf  = req_leaf_q;
  end

  always_comb begin
    for (int k = 0; k < NUM_LEAVES; k++) begin
      o_fifo[DATA_WIDTH*k +: DATA_WIDTH] = mem[k][rd_ptr[k]];
      o_fifo_empty[k] = (count[k] == '0);
    end
    o_leaf_done = done;
    o_overflow  = overflow;
  end

endmodule

// File: tb/tb_merger_tree_leaf_feeder.sv
module tb_merger_tree_leaf_feeder;
  localparam int NL = 16, DW = 16, DEPTH = 8, BURST = 4, LW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [DW*NL-1:0] fifo;
  logic [NL-1:0]   fifo_empty, leaf_done;
  logic [NL-1:0]   fifo_read = '0;
  logic            req_valid, overflow;
  logic [LW-1:0]   req_leaf;
  logic            req_ready = 1'b0, rsp_valid = 1'b0, rsp_last = 1'b0;
  logic [LW-1:0]   rsp_leaf = '0;
  logic [DW-1:0]   rsp_data = '0;

  int errors = 0, checks = 0;

  merger_tree_leaf_feeder #(.NUM_LEAVES(NL), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                            .BURST(BURST), .LEAF_W(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_fifo(fifo),
    .o_fifo_empty(fifo_empty), .i_fifo_read(fifo_read), .o_req_valid(req_valid),
    .o_req_leaf(req_leaf), .i_req_ready(req_ready), .i_rsp_valid(rsp_valid),
    .i_rsp_leaf(rsp_leaf), .i_rsp_data(rsp_data), .i_rsp_last(rsp_last),
    .o_leaf_done(leaf_done), .o_overflow(overflow));

  always #5 clk = ~clk;

  // Reference model: leaves as queues, credits as integers, request as a flag.
  logic [DW-1:0] mq [NL][$];
  int  m_pend [NL];
  bit  m_done [NL];
  bit  m_ovf, m_en, m_rv, m_hs;
  int  m_rr, m_rl, m_hs_leaf;

  function automatic void model_clear(bit enable);
    for (int k = 0; k < NL; k++) begin
      mq[k].delete();
      m_pend[k] = 0;
      m_done[k] = 0;
    end
    m_ovf = 0; m_en = enable; m_rv = 0; m_rl = 0; m_rr = 0; m_hs = 0;
  endfunction

  function automatic void model_step();
    bit found, acc;
    bit popk [NL];
    int pick, idx, k, p;
    m_hs = 0;
    if (start) begin
      model_clear(1'b1);
      return;
    end
    found = 0; pick = 0;
    if (!m_rv && m_en)
      for (int i = 0; i < NL; i++) begin
        idx = (m_rr + i) % NL;
        if (!found && !m_done[idx] && (DEPTH - mq[idx].size() - m_pend[idx]) >= BURST) begin
          found = 1; pick = idx;
        end
      end
    for (int j = 0; j < NL; j++) popk[j] = fifo_read[j] && (mq[j].size() > 0);
    acc = 0; k = int'(rsp_leaf);
    if (rsp_valid) begin
      if (mq[k].size() == DEPTH && !popk[k]) m_ovf = 1;
      else acc = 1;
    end
    for (int j = 0; j < NL; j++) if (popk[j]) void'(mq[j].pop_front());
    if (acc) mq[k].push_back(rsp_data);
    for (int j = 0; j < NL; j++) begin
      p = m_pend[j] + ((m_rv && req_ready && m_rl == j) ? BURST : 0);
      if (acc && j == k) begin
        if (p > 0) p--;
        if (rsp_last) begin p = 0; m_done[j] = 1; end
      end
      if (p > DEPTH) p = DEPTH;
      m_pend[j] = p;
    end
    if (m_rv) begin
      if (req_ready) begin
        m_hs = 1; m_hs_leaf = m_rl; m_rv = 0; m_rr = (m_rl + 1) % NL;
      end
    end else if (found) begin
      m_rv = 1; m_rl = pick;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_beat(int leaf, logic [DW-1:0] d, bit last);
    rsp_valid = 1'b1; rsp_leaf = LW'(leaf); rsp_data = d; rsp_last = last;
    cycle();
    rsp_valid = 1'b0; rsp_last = 1'b0;
  endtask

  task automatic pop_leaf(int leaf);
    fifo_read[leaf] = 1'b1;
    cycle();
    fifo_read = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear(1'b0);
    checks++; if (fifo_empty !== '1) begin errors++; $display("FAIL reset_empty: got %h want %h", fifo_empty, {NL{1'b1}}); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (req_leaf !== '0) begin errors++; $display("FAIL reset_req_leaf: got %0d want 0", req_leaf); end
    checks++; if (leaf_done !== '0) begin errors++; $display("FAIL reset_done: got %h want 0", leaf_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    req_ready = 1'b1;
    repeat (3) begin
      cycle();
      checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL idle_before_start: req_valid got %b want 0", req_valid); end
    end
  endtask

  task automatic test_refill_order();
    req_ready = 1'b1;
    pulse_start();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL start_cycle_valid: got %b want 0", req_valid); end
    for (int c = 1; c <= 2 * NL; c++) begin
      cycle();
      checks++;
      if (req_valid !== LW'(c % 2) || (c % 2 == 1 && req_leaf !== LW'((c - 1) / 2))) begin
        errors++;
        $display("FAIL refill_order c=%0d: got valid=%b leaf=%0d want valid=%0d leaf=%0d",
                 c, req_valid, req_leaf, c % 2, (c - 1) / 2);
      end
    end
    req_ready = 1'b0;
    cycle();
    checks++; if (req_valid !== 1'b1 || req_leaf !== '0) begin errors++; $display("FAIL second_request: got valid=%b leaf=%0d want 1/0", req_valid, req_leaf); end
  endtask

  task automatic test_hold_ready();
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++; if (req_valid !== 1'b1 || req_leaf !== '0) begin errors++; $display("FAIL hold_stable c=%0d: got valid=%b leaf=%0d want 1/0", c, req_valid, req_leaf); end
    end
    req_ready = 1'b1;
    cycle();
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hold_release: valid got %b want 0", req_valid); end
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++; if (req_valid !== 1'b1 || req_leaf !== LW'(1)) begin errors++; $display("FAIL hold_rr_advance c=%0d: got valid=%b leaf=%0d want 1/1", c, req_valid, req_leaf); end
    end
  endtask

  task automatic test_fill_pop();
    logic [DW-1:0] want [4] = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    send_beat(5, want[0], 1'b0);
    checks++; if (fifo_empty[5] !== 1'b0 || fifo[DW*5 +: DW] !== want[0]) begin errors++; $display("FAIL first_beat_visible: empty=%b head=%h want 0/%h", fifo_empty[5], fifo[DW*5 +: DW], want[0]); end
    for (int i = 1; i < 4; i++) send_beat(5, want[i], 1'b0);
    checks++; if (fifo[DW*5 +: DW] !== want[0]) begin errors++; $display("FAIL head_after_fill: got %h want %h", fifo[DW*5 +: DW], want[0]); end
    pop_leaf(5);
    pop_leaf(5);
    checks++; if (fifo_empty[5] !== 1'b0 || fifo[DW*5 +: DW] !== want[2]) begin errors++; $display("FAIL head_after_pops: empty=%b head=%h want 0/%h", fifo_empty[5], fifo[DW*5 +: DW], want[2]); end
    pop_leaf(5);
    checks++; if (fifo_empty[5] !== 1'b0 || fifo[DW*5 +: DW] !== want[3]) begin errors++; $display("FAIL head_third: empty=%b head=%h want 0/%h", fifo_empty[5], fifo[DW*5 +: DW], want[3]); end
    pop_leaf(5);
    checks++; if (fifo_empty[5] !== 1'b1) begin errors++; $display("FAIL leaf5_drained: empty got %b want 1", fifo_empty[5]); end
  endtask

  task automatic test_pop_write();
    send_beat(3, 16'h0030, 1'b0);
    send_beat(3, 16'h0031, 1'b0);
    fifo_read[3] = 1'b1;
    send_beat(3, 16'h0032, 1'b0);
    fifo_read = '0;
    checks++; if (fifo_empty[3] !== 1'b0 || fifo[DW*3 +: DW] !== 16'h0031) begin errors++; $display("FAIL pop_write_head: empty=%b head=%h want 0/0031", fifo_empty[3], fifo[DW*3 +: DW]); end
    pop_leaf(3);
    checks++; if (fifo[DW*3 +: DW] !== 16'h0032) begin errors++; $display("FAIL pop_write_order: got %h want 0032", fifo[DW*3 +: DW]); end
    pop_leaf(3);
    checks++; if (fifo_empty[3] !== 1'b1) begin errors++; $display("FAIL pop_write_count: empty got %b want 1", fifo_empty[3]); end
    pop_leaf(3);
    checks++; if (fifo_empty[3] !== 1'b1) begin errors++; $display("FAIL pop_on_empty: empty got %b want 1", fifo_empty[3]); end
    fifo_read[3] = 1'b1;
    send_beat(3, 16'h0033, 1'b0);
    fifo_read = '0;
    checks++; if (fifo_empty[3] !== 1'b0 || fifo[DW*3 +: DW] !== 16'h0033) begin errors++; $display("FAIL write_empty_with_pop: empty=%b head=%h want 0/0033", fifo_empty[3], fifo[DW*3 +: DW]); end
  endtask

  task automatic test_last();
    send_beat(9, 16'h0090, 1'b0);
    send_beat(9, 16'h0091, 1'b1);
    checks++; if (leaf_done !== 16'h0200) begin errors++; $display("FAIL leaf_done: got %h want 0200", leaf_done); end
    req_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      checks++;
      if (req_valid !== m_rv || (m_rv && req_leaf !== LW'(m_rl)) || (req_valid && req_leaf == LW'(9))) begin
        errors++;
        $display("FAIL done_never_requested c=%0d: got valid=%b leaf=%0d want valid=%b leaf=%0d (never 9)", c, req_valid, req_leaf, m_rv, m_rl);
      end
    end
    req_ready = 1'b0;
    checks++; if (fifo[DW*9 +: DW] !== 16'h0090) begin errors++; $display("FAIL done_drain_head: got %h want 0090", fifo[DW*9 +: DW]); end
    pop_leaf(9);
    checks++; if (fifo[DW*9 +: DW] !== 16'h0091 || fifo_empty[9] !== 1'b0) begin errors++; $display("FAIL done_drain_second: head=%h empty=%b want 0091/0", fifo[DW*9 +: DW], fifo_empty[9]); end
    pop_leaf(9);
    checks++; if (fifo_empty[9] !== 1'b1 || leaf_done[9] !== 1'b1) begin errors++; $display("FAIL done_drained: empty=%b done=%b want 1/1", fifo_empty[9], leaf_done[9]); end
  endtask

  task automatic test_overflow();
    req_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) send_beat(0, DW'(16'h00C0 + i), 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b want 0", overflow); end
    send_beat(0, 16'h00C8, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (fifo[0 +: DW] !== DW'(16'h00C0 + i)) begin errors++; $display("FAIL overflow_order i=%0d: got %h want %h", i, fifo[0 +: DW], 16'h00C0 + i); end
      pop_leaf(0);
    end
    checks++; if (fifo_empty[0] !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL overflow_dropped: empty=%b ovf=%b want 1/1", fifo_empty[0], overflow); end
    pulse_start();
    checks++; if (overflow !== 1'b0 || fifo_empty !== '1) begin errors++; $display("FAIL start_clears: ovf=%b empty=%h want 0/ffff", overflow, fifo_empty); end
  endtask

  task automatic test_async_reset();
    req_ready = 1'b1;
    pulse_start();
    cycle();
    send_beat(2, 16'h0022, 1'b0);
    send_beat(2, 16'h0023, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_clear(1'b0);
    checks++;
    if (fifo_empty !== '1 || req_valid !== 1'b0 || req_leaf !== '0 || leaf_done !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%h valid=%b leaf=%0d done=%h ovf=%b want ffff/0/0/0/0",
               fifo_empty, req_valid, req_leaf, leaf_done, overflow);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int eng_q [$];
    bit head_ok;
    int bad_k;
    pulse_start();
    for (int c = 0; c < 800; c++) begin
      req_ready = ($urandom_range(0, 3) != 0);
      fifo_read = NL'($urandom() & $urandom());
      if (eng_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        rsp_valid = 1'b1;
        rsp_leaf  = LW'(eng_q.pop_front());
        rsp_data  = DW'($urandom());
        rsp_last  = ($urandom_range(0, 40) == 0);
      end else begin
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
      end
      cycle();
      if (m_hs) repeat (BURST) eng_q.push_back(m_hs_leaf);
      checks++;
      if (req_valid !== m_rv || (m_rv && req_leaf !== LW'(m_rl))) begin
        errors++;
        $display("FAIL rand_req c=%0d: got valid=%b leaf=%0d want valid=%b leaf=%0d", c, req_valid, req_leaf, m_rv, m_rl);
      end
      head_ok = 1; bad_k = 0;
      for (int k = 0; k < NL; k++) begin
        checks++;
        if (fifo_empty[k] !== (mq[k].size() == 0) || leaf_done[k] !== m_done[k]) begin
          errors++;
          $display("FAIL rand_flags c=%0d leaf=%0d: empty=%b done=%b want empty=%0d done=%b", c, k, fifo_empty[k], leaf_done[k], mq[k].size() == 0, m_done[k]);
        end
        if (mq[k].size() > 0 && fifo[DW*k +: DW] !== mq[k][0] && head_ok) begin
          head_ok = 0; bad_k = k;
        end
      end
      checks++;
      if (!head_ok) begin
        errors++;
        $display("FAIL rand_head c=%0d leaf=%0d: got %h want %h", c, bad_k, fifo[DW*bad_k +: DW], mq[bad_k][0]);
      end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow c=%0d: got %b want %b", c, overflow, m_ovf); end
    end
    rsp_valid = 1'b0; rsp_last = 1'b0; fifo_read = '0; req_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL credit_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_refill_order();
    test_hold_ready();
    test_fill_pop();
    test_pop_write();
    test_last();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
